// File: rtl/cpu_defs.sv
// Shared CPU definitions: load opcode, funct3 load subtypes, ROB sentinel
// and the load unit's state encoding.
package cpu_defs;

    localparam int XLEN  = 32;
    localparam int ROB_W = 6;

    localparam logic [6:0] LOAD_OP = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [ROB_W-1:0] INVALID_ROB = 6'd16;

    typedef enum logic [1:0] {
        LU_IDLE  = 2'd0,
        LU_MEM   = 2'd1,
        LU_BCAST = 2'd2,
        LU_DRAIN = 2'd3
    } lu_state_t;

endpackage

// File: rtl/load_align_extend.sv
// Byte-lane extraction and sign/zero extension of a returned memory word,
// plus misalignment / illegal-subtype detection for a load.
module load_align_extend
    import cpu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] result,
    output logic            fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        result   = '0;
        fault    = 1'b0;
        unique case (load_type)
            F3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                fault  = addr_lo[0];
                result = {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                fault  = addr_lo[0];
                result = {{(XLEN-16){1'b0}}, half_sel};
            end
            F3_LW: begin
                fault  = (addr_lo != 2'b00);
                result = rdata;
            end
            default: fault = 1'b1;
        endcase
        // A faulting load always broadcasts zero data.
        if (fault) result = '0;
    end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load execution unit: issue capture, one-beat memory
// read, alignment/extension, and a granted broadcast on a CDB slot.
module load_unit
    import cpu_defs::*;
#(
    parameter int                XLEN        = cpu_defs::XLEN,
    parameter int                ROB_W       = cpu_defs::ROB_W,
    parameter logic [ROB_W-1:0]  INVALID_ROB = cpu_defs::INVALID_ROB
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_enable,
    input  logic [XLEN-1:0]  load_addr,
    input  logic [2:0]       load_type,
    input  logic [ROB_W-1:0] load_rob,
    input  logic             flush,
    output logic             busy,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             cdb_valid,
    output logic [XLEN-1:0]  cdb_data,
    output logic [ROB_W-1:0] cdb_rob,
    output logic             cdb_exc,
    input  logic             cdb_grant
);

    // Handshakes: mem_req/mem_addr hold until mem_ready is sampled high at a
    // posedge; cdb_valid/cdb_data/cdb_rob/cdb_exc hold until cdb_grant is
    // sampled high. Either ready/grant outside its own state is ignored.

    lu_state_t        state, state_next;
    logic [XLEN-1:0]  addr_q;
    logic [2:0]       type_q;
    logic [ROB_W-1:0] rob_q;
    logic [XLEN-1:0]  data_q;
    logic             exc_q;

    logic             capture;
    logic             capture_fault;
    logic             latch_result;

    logic [1:0]       align_addr;
    logic [2:0]       align_type;
    logic [XLEN-1:0]  align_result;
    logic             align_fault;

    // In IDLE the aligner classifies the incoming request; otherwise it
    // works on the captured load against the returned word.
    assign align_addr = (state == LU_IDLE) ? load_addr[1:0] : addr_q[1:0];
    assign align_type = (state == LU_IDLE) ? load_type      : type_q;

    load_align_extend #(.XLEN(XLEN)) u_align (
        .rdata     (mem_rdata),
        .addr_lo   (align_addr),
        .load_type (align_type),
        .result    (align_result),
        .fault     (align_fault)
    );

    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        capture_fault = 1'b0;
        latch_result  = 1'b0;
        unique case (state)
            LU_IDLE: begin
                if (load_enable && !flush) begin
                    capture       = 1'b1;
                    capture_fault = align_fault;
                    state_next    = align_fault ? LU_BCAST : LU_MEM;
                end
            end
            LU_MEM: begin
                if (mem_ready) begin
                    latch_result = !flush;
                    state_next   = flush ? LU_IDLE : LU_BCAST;
                end else if (flush) begin
                    state_next = LU_DRAIN;
                end
            end
            LU_DRAIN: begin
                if (mem_ready) state_next = LU_IDLE;
            end
            LU_BCAST: begin
                if (flush || cdb_grant) state_next = LU_IDLE;
            end
            default: state_next = LU_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= LU_IDLE;
            addr_q <= '0;
            type_q <= '0;
            rob_q  <= '0;
            data_q <= '0;
            exc_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q <= load_addr;
                type_q <= load_type;
                rob_q  <= load_rob;
                data_q <= '0;
                exc_q  <= capture_fault;
            end else if (latch_result) begin
                data_q <= align_result;
                exc_q  <= 1'b0;
            end
        end
    end

    assign busy      = (state != LU_IDLE);
    assign mem_req   = (state == LU_MEM) || (state == LU_DRAIN);
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign cdb_valid = (state == LU_BCAST);
    assign cdb_data  = cdb_valid ? data_q : '0;
    assign cdb_rob   = cdb_valid ? rob_q : INVALID_ROB;
    assign cdb_exc   = cdb_valid & exc_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomized checks of load_unit against an arithmetic model
// of RISC-V load semantics.
module tb_load_unit;

    logic        clock;
    logic        reset;
    logic        load_enable;
    logic [31:0] load_addr;
    logic [2:0]  load_type;
    logic [5:0]  load_rob;
    logic        flush;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [5:0]  cdb_rob;
    logic        cdb_exc;
    logic        cdb_grant;

    int total = 0;
    int bad   = 0;
    logic [38:0] exp_q[$];

    load_unit dut (
        .clock       (clock),
        .reset       (reset),
        .load_enable (load_enable),
        .load_addr   (load_addr),
        .load_type   (load_type),
        .load_rob    (load_rob),
        .flush       (flush),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_rob     (cdb_rob),
        .cdb_exc     (cdb_exc),
        .cdb_grant   (cdb_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Returns {fault, value} from load semantics using plain arithmetic.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [2:0] t,
                                          input logic [31:0] d);
        int unsigned lane = a % 4;
        logic [31:0] b = (d >> (8 * lane)) % 256;
        logic [31:0] h = (d >> (16 * (lane / 2))) % 65536;
        case (t)
            3'd0: return {1'b0, (b >= 128) ? b + 32'hFFFF_FF00 : b};
            3'd4: return {1'b0, b};
            3'd1: return (a % 2 != 0) ? 33'h1_0000_0000
                                      : {1'b0, (h >= 32768) ? h + 32'hFFFF_0000 : h};
            3'd5: return (a % 2 != 0) ? 33'h1_0000_0000 : {1'b0, h};
            3'd2: return (lane != 0) ? 33'h1_0000_0000 : {1'b0, d};
            default: return 33'h1_0000_0000;
        endcase
    endfunction

    // Issue at the current negedge; md stall cycles before mem_ready,
    // gd cycles before grant. Ends at the first IDLE negedge after grant.
    task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [5:0] r,
                           input logic [31:0] d, input int md, input int gd);
        logic [32:0] m;
        logic [38:0] e;
        m = model(a, t, d);
        exp_q.push_back({m[32], r, m[31:0]});
        load_enable = 1'b1; load_addr = a; load_type = t; load_rob = r;
        @(negedge clock);
        load_enable = 1'b0; load_addr = $urandom; load_type = 3'($urandom);
        if (!m[32]) begin
            for (int i = 0; i < md; i++) begin
                chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
                chk("stall_mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("stall_busy", {31'd0, busy}, 32'd1);
                chk("stall_no_cdb", {31'd0, cdb_valid}, 32'd0);
                load_enable = (i == 0);
                load_rob = r ^ 6'h3F;
                mem_rdata = $urandom;
                @(negedge clock);
            end
            load_enable = 1'b0;
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            mem_ready = 1'b1; mem_rdata = d;
            @(negedge clock);
            mem_ready = 1'b0; mem_rdata = $urandom;
        end else begin
            chk("fault_no_req", {31'd0, mem_req}, 32'd0);
        end
        e = exp_q.pop_front();
        for (int i = 0; i <= gd; i++) begin
            chk("cdb_valid", {31'd0, cdb_valid}, 32'd1);
            chk("cdb_data", cdb_data, e[31:0]);
            chk("cdb_rob", {26'd0, cdb_rob}, {26'd0, e[37:32]});
            chk("cdb_exc", {31'd0, cdb_exc}, {31'd0, e[38]});
            chk("bcast_busy", {31'd0, busy}, 32'd1);
            chk("bcast_no_req", {31'd0, mem_req}, 32'd0);
            load_enable = (i == 0 && gd > 0);
            cdb_grant = (i == gd);
            @(negedge clock);
        end
        load_enable = 1'b0;
        cdb_grant = 1'b0;
        chk("post_grant_valid", {31'd0, cdb_valid}, 32'd0);
        chk("post_grant_rob", {26'd0, cdb_rob}, 32'd16);
        chk("post_grant_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; load_enable = 1'b0; load_addr = '0; load_type = '0; load_rob = '0;
        flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
        @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_cdb_rob", {26'd0, cdb_rob}, 32'd16);
        chk("rst_cdb_exc", {31'd0, cdb_exc}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed loads, back-to-back issue after each grant.
        do_load(32'h100, 3'b010, 6'd5, 32'hDEADBEEF, 0, 0);
        do_load(32'h103, 3'b000, 6'd1, 32'h80FF1234, 0, 0);
        do_load(32'h103, 3'b100, 6'd2, 32'h80FF1234, 0, 0);
        do_load(32'h102, 3'b001, 6'd3, 32'h80017FFF, 0, 0);
        do_load(32'h100, 3'b101, 6'd4, 32'h80017FFF, 0, 0);
        do_load(32'h101, 3'b010, 6'd9, 32'h12345678, 0, 0);
        do_load(32'h100, 3'b111, 6'd9, 32'h12345678, 0, 0);
        do_load(32'h204, 3'b010, 6'd7, 32'hCAFEF00D, 4, 3);

        // Flush in MEM, memory answers 3 cycles later.
        load_enable = 1'b1; load_addr = 32'h300; load_type = 3'b010; load_rob = 6'd11;
        @(negedge clock);
        load_enable = 1'b0; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_req", {31'd0, mem_req}, 32'd1);
            chk("drain_addr", mem_addr, 32'h300);
            chk("drain_no_cdb", {31'd0, cdb_valid}, 32'd0);
            @(negedge clock);
        end
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clock);
        mem_ready = 1'b0;
        chk("drain_done_busy", {31'd0, busy}, 32'd0);
        chk("drain_done_req", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk("drain_no_bcast", {31'd0, cdb_valid}, 32'd0);

        // Flush coinciding with mem_ready discards the data.
        load_enable = 1'b1; load_addr = 32'h304; load_type = 3'b010; load_rob = 6'd12;
        @(negedge clock);
        load_enable = 1'b0; flush = 1'b1; mem_ready = 1'b1;
        @(negedge clock);
        flush = 1'b0; mem_ready = 1'b0;
        chk("flush_ready_busy", {31'd0, busy}, 32'd0);
        chk("flush_ready_valid", {31'd0, cdb_valid}, 32'd0);

        // Flush beats a same-cycle grant in BCAST.
        load_enable = 1'b1; load_addr = 32'h305; load_type = 3'b010; load_rob = 6'd13;
        @(negedge clock);
        load_enable = 1'b0;
        chk("fb_valid", {31'd0, cdb_valid}, 32'd1);
        flush = 1'b1; cdb_grant = 1'b1;
        @(negedge clock);
        flush = 1'b0; cdb_grant = 1'b0;
        chk("fb_dropped", {31'd0, cdb_valid}, 32'd0);
        chk("fb_busy", {31'd0, busy}, 32'd0);

        // Flush in IDLE masks a simultaneous issue.
        load_enable = 1'b1; flush = 1'b1; load_addr = 32'h400; load_type = 3'b010;
        @(negedge clock);
        load_enable = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {31'd0, busy}, 32'd0);

        // Async reset during BCAST.
        load_enable = 1'b1; load_addr = 32'h401; load_type = 3'b001; load_rob = 6'd20;
        @(negedge clock);
        load_enable = 1'b0;
        chk("pre_rst_valid", {31'd0, cdb_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_bcast_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_bcast_rob", {26'd0, cdb_rob}, 32'd16);
        chk("rst_bcast_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Async reset mid-MEM, then a late mem_ready in IDLE.
        load_enable = 1'b1; load_addr = 32'h500; load_type = 3'b010; load_rob = 6'd21;
        @(negedge clock);
        load_enable = 1'b0;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mem_req_drop", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        chk("late_ready_busy", {31'd0, busy}, 32'd0);
        chk("late_ready_valid", {31'd0, cdb_valid}, 32'd0);

        // Randomized loads with random stalls.
        for (int n = 0; n < 60; n++) begin
            do_load($urandom, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
